// File: rtl/ram_bank_ctrl_if.sv
// Host-side request bus of the parity DRAM bank controller.
// Handshake: the master raises req with wr/addr/wdata stable and holds all of them
// until the slave returns a one-cycle ack; on a read, rdata is valid while ack is high.
interface ram_bank_ctrl_if;
  logic        req;
  logic        wr;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ack;

  modport master (
    output req,
    output wr,
    output addr,
    output wdata,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  wr,
    input  addr,
    input  wdata,
    output rdata,
    output ack
  );
endinterface

// File: rtl/ram_bank_ctrl.sv
// RAS/CAS sequencer for one 64 KB parity DRAM bank with interleaved RAS-only refresh.
// Optional read parity checking is enabled by defining PARITY_CHECK_EN.
module ram_bank_ctrl #(
  parameter int T_RCD   = 2,
  parameter int T_CAS   = 2,
  parameter int T_RP    = 2,
  parameter int T_RAS   = 3,
  parameter int REF_MAX = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  ram_bank_ctrl_if.slave bus,
  input  logic           ref_tick,
  output logic [7:0]     ref_row,
  output logic [7:0]     ma,
  output logic [7:0]     md_out,
  output logic           mdp_out,
  output logic           md_oe,
  input  logic [7:0]     md_in,
  input  logic           mdp_in,
  output logic           ras_n,
  output logic           cas_n,
  output logic           we_n,
  output logic           par_err,
  input  logic           par_clr,
  output logic [2:0]     state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ROW  = 3'd1,
    COL  = 3'd2,
    REF  = 3'd3,
    PRE  = 3'd4
  } state_t;

  // Counter reload values: the counter runs down to zero in the last cycle of a state.
  localparam logic [3:0] RCD_L    = 4'(T_RCD - 1);
  localparam logic [3:0] CAS_L    = 4'(T_CAS - 1);
  localparam logic [3:0] RP_L     = 4'(T_RP - 1);
  localparam logic [3:0] RAS_L    = 4'(T_RAS - 1);
  localparam logic [1:0] PEND_MAX = 2'(REF_MAX);

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] pending;

  logic last;
  logic decide;
  logic want_ref;
  logic ref_done;
  logic rd_sample;

  // The end of PRE takes the same decision as IDLE so back-to-back accesses lose no cycle.
  // A ref_tick arriving with a request wins, so the refresh goes first.
  always_comb begin
    last      = (cnt == 4'd0);
    decide    = (state == IDLE) || ((state == PRE) && last);
    want_ref  = (pending != 2'd0) || ref_tick;
    ref_done  = (state == REF) && last;
    rd_sample = (state == COL) && last && !bus.wr;
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 2'd0;
    end else begin
      case ({ref_tick, ref_done})
        2'b10: if (pending != PEND_MAX) pending <= pending + 2'd1;
        2'b01: pending <= pending - 2'd1;
        default: pending <= pending;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ras_n     <= 1'b1;
      cas_n     <= 1'b1;
      we_n      <= 1'b1;
      ma        <= 8'h00;
      md_out    <= 8'h00;
      mdp_out   <= 1'b0;
      md_oe     <= 1'b0;
      bus.ack   <= 1'b0;
      bus.rdata <= 8'h00;
      ref_row   <= 8'h00;
    end else begin
      bus.ack <= 1'b0;
      if (decide) begin
        if (want_ref) begin
          state <= REF;
          cnt   <= RAS_L;
          ras_n <= 1'b0;
          cas_n <= 1'b1;
          we_n  <= 1'b1;
          ma    <= ref_row;
        end else if (bus.req) begin
          state <= ROW;
          cnt   <= RCD_L;
          ras_n <= 1'b0;
          cas_n <= 1'b1;
          we_n  <= 1'b1;
          ma    <= bus.addr[15:8];
        end else begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      end else begin
        case (state)
          ROW: begin
            if (last) begin
              state   <= COL;
              cnt     <= CAS_L;
              cas_n   <= 1'b0;
              ma      <= bus.addr[7:0];
              we_n    <= ~bus.wr;
              md_oe   <= bus.wr;
              md_out  <= bus.wdata;
              mdp_out <= ~^bus.wdata;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          COL: begin
            if (last) begin
              state   <= PRE;
              cnt     <= RP_L;
              ras_n   <= 1'b1;
              cas_n   <= 1'b1;
              we_n    <= 1'b1;
              md_oe   <= 1'b0;
              bus.ack <= 1'b1;
              if (rd_sample) bus.rdata <= md_in;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          REF: begin
            if (last) begin
              state   <= PRE;
              cnt     <= RP_L;
              ras_n   <= 1'b1;
              ref_row <= ref_row + 8'd1;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          default: cnt <= cnt - 4'd1;
        endcase
      end
    end
  end

`ifdef PARITY_CHECK_EN
  // Stored word plus parity must have odd weight; a clear wins over a fresh error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else if (par_clr) begin
      par_err <= 1'b0;
    end else if (rd_sample && !(^{md_in, mdp_in})) begin
      par_err <= 1'b1;
    end
  end
`else
  assign par_err = 1'b0;
  logic unused_parity;
  assign unused_parity = ^{par_clr, mdp_in};
`endif

endmodule

// File: tb/tb_ram_bank_ctrl.sv
// Directed bench for ram_bank_ctrl with a behavioural parity DRAM bank model.
// Parity-error expectations follow PARITY_CHECK_EN.
module tb_ram_bank_ctrl;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ROW  = 3'd1;
  localparam logic [2:0] S_REF  = 3'd3;
`ifdef PARITY_CHECK_EN
  localparam logic PAR_EXP = 1'b1;
`else
  localparam logic PAR_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ref_tick;
  logic [7:0] ref_row;
  logic [7:0] ma;
  logic [7:0] md_out;
  logic       mdp_out;
  logic       md_oe;
  logic [7:0] md_in;
  logic       mdp_in;
  logic       ras_n;
  logic       cas_n;
  logic       we_n;
  logic       par_err;
  logic       par_clr;
  logic [2:0] state_dbg;

  ram_bank_ctrl_if bus ();

  ram_bank_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ref_tick  (ref_tick),
    .ref_row   (ref_row),
    .ma        (ma),
    .md_out    (md_out),
    .mdp_out   (mdp_out),
    .md_oe     (md_oe),
    .md_in     (md_in),
    .mdp_in    (mdp_in),
    .ras_n     (ras_n),
    .cas_n     (cas_n),
    .we_n      (we_n),
    .par_err   (par_err),
    .par_clr   (par_clr),
    .state_dbg (state_dbg)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural bank: row latched while RAS is low and CAS high, writes on CAS+WE
  logic [8:0] mem [0:65535];
  logic [7:0] row_q = 8'h00;
  logic       bad_bank = 1'b0;
  logic [8:0] rd_word;
  assign rd_word = mem[{row_q, ma}];
  assign md_in   = bad_bank ? 8'h00 : rd_word[7:0];
  assign mdp_in  = bad_bank ? 1'b0  : rd_word[8];
  always @(negedge clk) if (!ras_n && cas_n) row_q = ma;
  always @(posedge clk) if (!cas_n && !we_n && md_oe) mem[{row_q, ma}] <= {mdp_out, md_out};

  // monitors
  int       ack_cnt = 0;
  int       ack_cyc = 0;
  int       ref_cnt = 0;
  logic [2:0] prev_state = 3'd0;
  always @(negedge clk) begin
    if (bus.ack === 1'b1) begin
      ack_cnt++;
      ack_cyc = cyc;
    end
    if (state_dbg == S_REF && prev_state != S_REF) ref_cnt++;
    prev_state = state_dbg;
  end

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_req(input logic w, input logic [15:0] a, input logic [7:0] d);
    bus.req   = 1'b1;
    bus.wr    = w;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  task automatic wait_ack(input string tag, input int t0, output int lat);
    bit got;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.ack === 1'b1) begin
        got = 1'b1;
        lat = cyc - t0;
      end
    end
    chk({tag, "_ack_seen"}, 32'(got), 32'd1);
  endtask

  int t0;
  int lat;
  int ack0;
  int ref0;
  logic [7:0] old_row;

  initial begin
    bus.req = 1'b0; bus.wr = 1'b0; bus.addr = 16'h0000; bus.wdata = 8'h00;
    ref_tick = 1'b0; par_clr = 1'b0;

    // reset state
    tick_clk(2);
    chk("rst_ras_n", 32'(ras_n), 32'd1);
    chk("rst_cas_n", 32'(cas_n), 32'd1);
    chk("rst_we_n", 32'(we_n), 32'd1);
    chk("rst_md_oe", 32'(md_oe), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_ma", 32'(ma), 32'h00);
    chk("rst_rdata", 32'(bus.rdata), 32'h00);
    chk("rst_ref_row", 32'(ref_row), 32'h00);
    chk("rst_par_err", 32'(par_err), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    rst_n = 1'b1;
    tick_clk(2);

    // 1: write 12A5 <= 3C
    t0 = cyc;
    drive_req(1'b1, 16'h12A5, 8'h3C);
    tick_clk(1);
    chk("wr_row_state", 32'(state_dbg), 32'(S_ROW));
    chk("wr_row_ras_n", 32'(ras_n), 32'd0);
    chk("wr_row_ma", 32'(ma), 32'h12);
    chk("wr_row_we_n", 32'(we_n), 32'd1);
    tick_clk(1);
    chk("wr_row2_cas_n", 32'(cas_n), 32'd1);
    tick_clk(1);
    chk("wr_col_cas_n", 32'(cas_n), 32'd0);
    chk("wr_col_ma", 32'(ma), 32'hA5);
    chk("wr_col_we_n", 32'(we_n), 32'd0);
    chk("wr_col_md_oe", 32'(md_oe), 32'd1);
    chk("wr_col_md_out", 32'(md_out), 32'h3C);
    chk("wr_col_mdp_out", 32'(mdp_out), 32'd1);
    wait_ack("wr", t0, lat);
    chk("wr_ack_latency", 32'(lat), 32'd5);
    chk("wr_ack_ras_n", 32'(ras_n), 32'd1);
    bus.req = 1'b0;
    tick_clk(1);
    chk("wr_ack_one_cycle", 32'(bus.ack), 32'd0);
    tick_clk(1);
    chk("wr_back_idle", 32'(state_dbg), 32'(S_IDLE));

    // 2: read back
    t0 = cyc;
    drive_req(1'b0, 16'h12A5, 8'h00);
    wait_ack("rd", t0, lat);
    chk("rd_ack_latency", 32'(lat), 32'd5);
    chk("rd_rdata", 32'(bus.rdata), 32'h3C);
    chk("rd_strobes_high", 32'({ras_n, cas_n, we_n}), 32'b111);
    chk("rd_md_oe", 32'(md_oe), 32'd0);
    bus.req = 1'b0;
    tick_clk(2);

    // 3: ref_tick with req: refresh first, read delayed by REF+PRE (3+2 cycles)
    t0 = cyc;
    drive_req(1'b0, 16'h12A5, 8'h00);
    ref_tick = 1'b1;
    tick_clk(1);
    ref_tick = 1'b0;
    chk("ref_first_state", 32'(state_dbg), 32'(S_REF));
    chk("ref_first_strobes", 32'({ras_n, cas_n, we_n}), 32'b011);
    chk("ref_first_ma", 32'(ma), 32'h00);
    wait_ack("ref_rd", t0, lat);
    chk("ref_rd_latency", 32'(lat), 32'd10);
    chk("ref_rd_rdata", 32'(bus.rdata), 32'h3C);
    chk("ref_row_inc", 32'(ref_row), 32'h01);
    bus.req = 1'b0;
    tick_clk(2);

    // 4: five ticks during a busy write saturate pending at 3
    ref0 = ref_cnt;
    ack0 = ack_cnt;
    t0 = cyc;
    drive_req(1'b1, 16'hBE07, 8'hC1);
    tick_clk(1);
    ref_tick = 1'b1;
    tick_clk(2);
    chk("sat_col_mdp_out", 32'(mdp_out), 32'd0);
    chk("sat_col_we_n", 32'(we_n), 32'd0);
    tick_clk(2);
    chk("sat_wr_ack", 32'(bus.ack), 32'd1);
    tick_clk(1);
    ref_tick = 1'b0;
    bus.req = 1'b0;
    tick_clk(30);
    chk("sat_ref_count", 32'(ref_cnt - ref0), 32'd3);
    chk("sat_ref_row", 32'(ref_row), 32'h04);
    chk("sat_ack_count", 32'(ack_cnt - ack0), 32'd1);
    chk("sat_ack_cycle", 32'(ack_cyc - t0), 32'd5);
    chk("sat_idle", 32'(state_dbg), 32'(S_IDLE));

    // back-to-back reads: one access per 6 cycles
    t0 = cyc;
    drive_req(1'b0, 16'h12A5, 8'h00);
    wait_ack("b2b_a", t0, lat);
    chk("b2b_a_latency", 32'(lat), 32'd5);
    chk("b2b_a_rdata", 32'(bus.rdata), 32'h3C);
    bus.addr = 16'hBE07;
    wait_ack("b2b_b", t0, lat);
    chk("b2b_b_latency", 32'(lat), 32'd11);
    chk("b2b_b_rdata", 32'(bus.rdata), 32'hC1);
    bus.req = 1'b0;
    tick_clk(2);

    // ref_row wrap 255 -> 0
    for (int i = 0; i < 300 && ref_row != 8'hFF; i++) begin
      ref_tick = 1'b1;
      tick_clk(1);
      ref_tick = 1'b0;
      old_row = ref_row;
      for (int j = 0; j < 20 && ref_row == old_row; j++) tick_clk(1);
    end
    tick_clk(4);
    chk("wrap_pre_row", 32'(ref_row), 32'hFF);
    ref_tick = 1'b1;
    tick_clk(1);
    ref_tick = 1'b0;
    chk("wrap_ref_ma", 32'(ma), 32'hFF);
    tick_clk(8);
    chk("wrap_ref_row", 32'(ref_row), 32'h00);

    // 5: async reset during the COL phase of a write
    t0 = cyc;
    drive_req(1'b1, 16'h4321, 8'h81);
    tick_clk(3);
    chk("arst_pre_cas_n", 32'(cas_n), 32'd0);
    ack0 = ack_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_strobes", 32'({ras_n, cas_n, we_n}), 32'b111);
    chk("arst_md_oe", 32'(md_oe), 32'd0);
    chk("arst_state", 32'(state_dbg), 32'(S_IDLE));
    bus.req = 1'b0;
    tick_clk(1);
    rst_n = 1'b1;
    tick_clk(10);
    chk("arst_no_ack", 32'(ack_cnt - ack0), 32'd0);
    chk("arst_ras_n_idle", 32'(ras_n), 32'd1);

    // 6: bad parity from the bank
    bad_bank = 1'b1;
    t0 = cyc;
    drive_req(1'b0, 16'h12A5, 8'h00);
    wait_ack("par", t0, lat);
    chk("par_rdata", 32'(bus.rdata), 32'h00);
    chk("par_err_set", 32'(par_err), 32'(PAR_EXP));
    bus.req = 1'b0;
    bad_bank = 1'b0;
    tick_clk(3);
    chk("par_err_sticky", 32'(par_err), 32'(PAR_EXP));
    par_clr = 1'b1;
    tick_clk(1);
    par_clr = 1'b0;
    chk("par_err_clr", 32'(par_err), 32'd0);
    t0 = cyc;
    drive_req(1'b0, 16'h12A5, 8'h00);
    wait_ack("par_good", t0, lat);
    chk("par_good_rdata", 32'(bus.rdata), 32'h3C);
    chk("par_good_no_err", 32'(par_err), 32'd0);
    bus.req = 1'b0;
    tick_clk(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
